iobus_timer: RTL and testbench
==============================

IOBUS_TIMER -- requirements
Module: iobus_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1100_0100, word-aligned base of the 5-word register window.
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port IOBUS_ADDR  input  32  byte address driven by the CPU.
REQ-005 SHALL have port IOBUS_OUT  input  32  CPU write data.
REQ-006 SHALL have port IOBUS_WR  input  1  write strobe; one-cycle write when high.
REQ-007 SHALL have port IOBUS_IN  output  32  read data returned to the CPU.
REQ-008 SHALL have port INTR  output  1  level interrupt request to the CPU.

Function
REQ-009 SHALL decode offsets from BASE_ADDR: 0x00 CTRL (RW), 0x04 LOAD (RW), 0x08 PRESCALE (RW, bits[7:0]), 0x0C COUNT (RO), 0x10 STATUS (bit0 PEND, write-1-to-clear).
REQ-010 SHALL define CTRL bits: [0] EN, [1] AUTO (auto-reload), [2] IE (interrupt enable); bits [31:3] read 0.
REQ-011 SHALL drive IOBUS_IN combinationally from IOBUS_ADDR with zero latency; unmapped or misaligned addresses read 32'h0.
REQ-012 SHALL ignore writes with IOBUS_WR low, to unmapped addresses, or to COUNT.
REQ-013 SHALL implement a two-state FSM: IDLE (EN=0) and RUN (EN=1).
REQ-014 IDLE->RUN on a CTRL write setting EN: same edge loads COUNT<=LOAD and clears the prescale counter.
REQ-015 RUN->IDLE on a CTRL write clearing EN; COUNT holds its value.
REQ-016 In RUN, SHALL generate one tick every PRESCALE+1 cycles (PRESCALE=0 gives a tick every cycle) via an 8-bit prescale counter.
REQ-017 On a tick with COUNT!=0, SHALL decrement COUNT by 1 (32-bit, no wrap below 0).
REQ-018 On a tick with COUNT==0, SHALL set PEND; if AUTO=1, COUNT<=LOAD and remain in RUN; if AUTO=0, clear EN and go to IDLE.
REQ-019 LOAD=0 with AUTO=1 SHALL set PEND on every tick.
REQ-020 A LOAD write while in RUN SHALL NOT affect COUNT until the next reload or EN rising.
REQ-021 Expiry and a STATUS W1C in the same cycle: set SHALL win, PEND=1.
REQ-022 A CTRL write in the same cycle as an expiry: the CPU write SHALL take precedence for EN/AUTO/IE; PEND still sets.
REQ-023 INTR SHALL equal PEND & IE, registered-state driven, no combinational path from IOBUS inputs.
REQ-024 Writing STATUS with bit0=0 SHALL leave PEND unchanged.

Reset
REQ-025 On RST_N low, asynchronously: CTRL=0, LOAD=0, PRESCALE=0, COUNT=0, prescale counter=0, PEND=0, FSM=IDLE, hence INTR=0.
REQ-026 Reset asserted mid-count SHALL abandon the count; no PEND is produced after release until a new EN write.
REQ-027 IOBUS_IN during reset SHALL reflect the reset register values (0 for all mapped addresses).

Structure
REQ-028 Package iobus_timer_pkg SHALL hold register offsets, CTRL/STATUS bit indices and the IDLE/RUN state enum.
REQ-029 Prescale counter and tick generation SHALL be the sub-module iobus_timer_prescale (inputs CLK, RST_N, clear, enable, PRESCALE; output tick).
REQ-030 Top SHALL contain address decode, register file, COUNT/FSM logic and interrupt logic.

Verification
REQ-031 Reset then read all five offsets -> each returns 32'h0, INTR=0.
REQ-032 LOAD=3, PRESCALE=0, CTRL=0x5 -> COUNT reads 3,2,1,0 on successive cycles; PEND and INTR rise the cycle after COUNT=0; EN reads 0.
REQ-033 LOAD=2, PRESCALE=1, CTRL=0x7 -> PEND every 6 cycles; W1C to STATUS drops INTR next cycle; COUNT reloads to 2.
REQ-034 W1C to STATUS issued in the expiry cycle -> PEND stays 1, INTR stays 1.
REQ-035 RST_N pulsed low with COUNT=5 in RUN -> all outputs 0 immediately; no INTR for 20 cycles after release.
REQ-036 Write 0xFFFF_FFFF to BASE_ADDR+0x14 and to COUNT -> no register changes; reads of 0x14 return 0.

Source files
------------

// File: rtl/iobus_timer_pkg.sv
// Shared constants and types for the memory-mapped down-counting timer.
package iobus_timer_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned PRESCALE_W = 8;

    // Register offsets from the block base address
    localparam logic [ADDR_W-1:0] OFF_CTRL     = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] OFF_LOAD     = 32'h0000_0004;
    localparam logic [ADDR_W-1:0] OFF_PRESCALE = 32'h0000_0008;
    localparam logic [ADDR_W-1:0] OFF_COUNT    = 32'h0000_000C;
    localparam logic [ADDR_W-1:0] OFF_STATUS   = 32'h0000_0010;

    // CTRL / STATUS bit positions
    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_AUTO_BIT   = 1;
    localparam int unsigned CTRL_IE_BIT     = 2;
    localparam int unsigned STATUS_PEND_BIT = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/iobus_timer_prescale.sv
// Prescale counter: emits one tick every PRESCALE+1 enabled cycles.
module iobus_timer_prescale
    import iobus_timer_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] cnt_d;

    // Tick on terminal count; >= keeps a lowered PRESCALE from forcing a full wrap
    always_comb begin
        tick = enable && (cnt_q >= PRESCALE);
    end

    // Next prescale count: clear wins, then count or restart on tick
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + PRESCALE_W'(1);
        end
    end

    // Prescale counter register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/iobus_timer.sv
// IOBUS timer: register window, down-counter FSM and level interrupt.
module iobus_timer
    import iobus_timer_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h1100_0100
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] IOBUS_ADDR,
    input  logic [DATA_W-1:0] IOBUS_OUT,
    input  logic              IOBUS_WR,
    output logic [DATA_W-1:0] IOBUS_IN,
    output logic              INTR
);

    state_e                state_q,    state_d;
    logic                  auto_q,     auto_d;
    logic                  ie_q,       ie_d;
    logic [DATA_W-1:0]     load_q,     load_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [DATA_W-1:0]     count_q,    count_d;
    logic                  pend_q,     pend_d;
    logic                  intr_q,     intr_d;

    logic sel_ctrl, sel_load, sel_prescale, sel_count, sel_status;
    logic ctrl_wr, load_wr, prescale_wr, status_wr;
    logic start, tick, tick_run, expire;

    // Exact-match address decode; misaligned addresses match nothing
    always_comb begin
        sel_ctrl     = (IOBUS_ADDR == BASE_ADDR + OFF_CTRL);
        sel_load     = (IOBUS_ADDR == BASE_ADDR + OFF_LOAD);
        sel_prescale = (IOBUS_ADDR == BASE_ADDR + OFF_PRESCALE);
        sel_count    = (IOBUS_ADDR == BASE_ADDR + OFF_COUNT);
        sel_status   = (IOBUS_ADDR == BASE_ADDR + OFF_STATUS);
        ctrl_wr      = IOBUS_WR && sel_ctrl;
        load_wr      = IOBUS_WR && sel_load;
        prescale_wr  = IOBUS_WR && sel_prescale;
        status_wr    = IOBUS_WR && sel_status;
    end

    // Timer events: EN rising, a tick while running, and expiry at zero
    always_comb begin
        start    = (state_q == ST_IDLE) && ctrl_wr && IOBUS_OUT[CTRL_EN_BIT];
        tick_run = (state_q == ST_RUN) && tick;
        expire   = tick_run && (count_q == '0);
    end

    iobus_timer_prescale u_prescale (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .clear    (start),
        .enable   (state_q == ST_RUN),
        .PRESCALE (prescale_q),
        .tick     (tick)
    );

    // Next-state for registers, COUNT, FSM and pending flag
    always_comb begin
        state_d    = state_q;
        auto_d     = auto_q;
        ie_d       = ie_q;
        load_d     = load_q;
        prescale_d = prescale_q;
        count_d    = count_q;
        pend_d     = pend_q;

        if (load_wr) begin
            load_d = IOBUS_OUT;
        end
        if (prescale_wr) begin
            prescale_d = IOBUS_OUT[PRESCALE_W-1:0];
        end

        // COUNT: decrement per tick, reload on auto expiry or EN rising
        if (tick_run) begin
            if (count_q != '0) begin
                count_d = count_q - DATA_W'(1);
            end else if (auto_q) begin
                count_d = load_q;
            end
        end
        if (start) begin
            count_d = load_q;
        end

        // FSM: one-shot expiry stops the timer
        if (state_q == ST_IDLE) begin
            if (start) begin
                state_d = ST_RUN;
            end
        end else begin
            if (expire && !auto_q) begin
                state_d = ST_IDLE;
            end
        end

        // A CPU CTRL write overrides any hardware update of EN/AUTO/IE
        if (ctrl_wr) begin
            state_d = IOBUS_OUT[CTRL_EN_BIT] ? ST_RUN : ST_IDLE;
            auto_d  = IOBUS_OUT[CTRL_AUTO_BIT];
            ie_d    = IOBUS_OUT[CTRL_IE_BIT];
        end

        // PEND: write-1-to-clear, expiry set has priority
        if (status_wr && IOBUS_OUT[STATUS_PEND_BIT]) begin
            pend_d = 1'b0;
        end
        if (expire) begin
            pend_d = 1'b1;
        end

        intr_d = pend_d && ie_d;
    end

    // State and register file flops
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            auto_q     <= 1'b0;
            ie_q       <= 1'b0;
            load_q     <= '0;
            prescale_q <= '0;
            count_q    <= '0;
            pend_q     <= 1'b0;
            intr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            auto_q     <= auto_d;
            ie_q       <= ie_d;
            load_q     <= load_d;
            prescale_q <= prescale_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
            intr_q     <= intr_d;
        end
    end

    // Zero-latency read mux; unmapped addresses return zero
    always_comb begin
        IOBUS_IN = '0;
        if (sel_ctrl) begin
            IOBUS_IN[CTRL_EN_BIT]   = (state_q == ST_RUN);
            IOBUS_IN[CTRL_AUTO_BIT] = auto_q;
            IOBUS_IN[CTRL_IE_BIT]   = ie_q;
        end else if (sel_load) begin
            IOBUS_IN = load_q;
        end else if (sel_prescale) begin
            IOBUS_IN = DATA_W'(prescale_q);
        end else if (sel_count) begin
            IOBUS_IN = count_q;
        end else if (sel_status) begin
            IOBUS_IN[STATUS_PEND_BIT] = pend_q;
        end
    end

    assign INTR = intr_q;

endmodule

// File: tb/tb_iobus_timer.sv
// Directed bench for iobus_timer with hand-computed expectations.
module tb_iobus_timer;

    localparam logic [31:0] BASE = 32'h1100_0100;

    logic        CLK;
    logic        RST_N;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] IOBUS_IN;
    logic        INTR;

    int n_vec;
    int n_bad;

    iobus_timer #(.BASE_ADDR(BASE)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .IOBUS_IN   (IOBUS_IN),
        .INTR       (INTR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Read one offset combinationally and compare
    task automatic rd_chk(input string tag, input logic [31:0] off, input logic [31:0] exp);
        IOBUS_ADDR = BASE + off;
        #1;
        check(tag, IOBUS_IN, exp);
    endtask

    task automatic intr_chk(input string tag, input logic exp);
        check(tag, {31'b0, INTR}, {31'b0, exp});
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One-cycle write; returns 1ns after the capturing edge
    task automatic wr(input logic [31:0] off, input logic [31:0] data);
        IOBUS_ADDR = BASE + off;
        IOBUS_OUT  = data;
        IOBUS_WR   = 1'b1;
        @(posedge CLK);
        #1;
        IOBUS_WR   = 1'b0;
    endtask

    initial begin
        n_vec      = 0;
        n_bad      = 0;
        RST_N      = 1'b0;
        IOBUS_ADDR = BASE;
        IOBUS_OUT  = '0;
        IOBUS_WR   = 1'b0;
        step();
        step();
        RST_N = 1'b1;
        step();

        // Reset state of all five registers
        rd_chk("rst_ctrl",     32'h00, 32'h0);
        rd_chk("rst_load",     32'h04, 32'h0);
        rd_chk("rst_prescale", 32'h08, 32'h0);
        rd_chk("rst_count",    32'h0C, 32'h0);
        rd_chk("rst_status",   32'h10, 32'h0);
        intr_chk("rst_intr", 1'b0);

        // Ignored writes: unmapped, COUNT, WR low; PRESCALE keeps 8 bits
        wr(32'h04, 32'h0000_0007);
        wr(32'h14, 32'hFFFF_FFFF);
        wr(32'h0C, 32'hFFFF_FFFF);
        IOBUS_ADDR = BASE + 32'h04;
        IOBUS_OUT  = 32'h0000_00AA;
        step();
        rd_chk("ign_load",   32'h04, 32'h7);
        rd_chk("ign_count",  32'h0C, 32'h0);
        rd_chk("ign_ctrl",   32'h00, 32'h0);
        rd_chk("ign_status", 32'h10, 32'h0);
        rd_chk("ign_0x14",   32'h14, 32'h0);
        rd_chk("misaligned", 32'h05, 32'h0);
        wr(32'h08, 32'h0000_01FF);
        rd_chk("pre_mask", 32'h08, 32'h0000_00FF);

        // One-shot: LOAD=3, PRESCALE=0, EN|IE
        wr(32'h04, 32'd3);
        wr(32'h08, 32'd0);
        wr(32'h00, 32'h5);
        rd_chk("os_cnt3", 32'h0C, 32'd3);
        step();
        rd_chk("os_cnt2", 32'h0C, 32'd2);
        step();
        rd_chk("os_cnt1", 32'h0C, 32'd1);
        step();
        rd_chk("os_cnt0", 32'h0C, 32'd0);
        rd_chk("os_pend0", 32'h10, 32'h0);
        intr_chk("os_intr0", 1'b0);
        step();
        rd_chk("os_pend1", 32'h10, 32'h1);
        intr_chk("os_intr1", 1'b1);
        rd_chk("os_ctrl", 32'h00, 32'h4);
        rd_chk("os_cnt_hold", 32'h0C, 32'd0);

        // STATUS write with bit0=0 leaves PEND alone
        wr(32'h10, 32'hFFFF_FFFE);
        rd_chk("w0_pend", 32'h10, 32'h1);
        wr(32'h10, 32'h1);
        intr_chk("w1c_intr", 1'b0);

        // CTRL write during expiry: CPU wins for EN/AUTO, PEND still sets
        wr(32'h04, 32'd1);
        wr(32'h00, 32'h5);
        rd_chk("cx_cnt1", 32'h0C, 32'd1);
        step();
        rd_chk("cx_cnt0", 32'h0C, 32'd0);
        wr(32'h00, 32'h7);
        rd_chk("cx_ctrl", 32'h00, 32'h7);
        rd_chk("cx_pend", 32'h10, 32'h1);
        rd_chk("cx_cnt_hold", 32'h0C, 32'd0);
        step();
        rd_chk("cx_reload", 32'h0C, 32'd1);

        // Auto-reload: LOAD=2, PRESCALE=1, EN|AUTO|IE
        wr(32'h00, 32'h0);
        wr(32'h10, 32'h1);
        intr_chk("ar_clr", 1'b0);
        wr(32'h04, 32'd2);
        wr(32'h08, 32'd1);
        wr(32'h00, 32'h7);
        rd_chk("ar_c0", 32'h0C, 32'd2);
        step();
        rd_chk("ar_c1", 32'h0C, 32'd2);
        step();
        rd_chk("ar_c2", 32'h0C, 32'd1);
        step();
        step();
        rd_chk("ar_c4", 32'h0C, 32'd0);
        step();
        rd_chk("ar_p5", 32'h10, 32'h0);
        step();
        rd_chk("ar_p6", 32'h10, 32'h1);
        intr_chk("ar_i6", 1'b1);
        rd_chk("ar_c6", 32'h0C, 32'd2);
        wr(32'h10, 32'h1);
        rd_chk("ar_p7", 32'h10, 32'h0);
        intr_chk("ar_i7", 1'b0);
        step();
        rd_chk("ar_c8", 32'h0C, 32'd1);
        step();
        step();
        step();
        rd_chk("ar_c11", 32'h0C, 32'd0);
        // W1C in the expiry cycle: set wins
        wr(32'h10, 32'h1);
        rd_chk("race_pend", 32'h10, 32'h1);
        intr_chk("race_intr", 1'b1);
        rd_chk("race_cnt", 32'h0C, 32'd2);

        // LOAD write in RUN does not disturb COUNT
        wr(32'h04, 32'd5);
        rd_chk("ld_run_cnt", 32'h0C, 32'd2);
        rd_chk("ld_run_load", 32'h04, 32'd5);

        // Reset mid-count with COUNT=5 in RUN
        wr(32'h00, 32'h4);
        intr_chk("pre_rst_intr", 1'b1);
        wr(32'h08, 32'd3);
        wr(32'h00, 32'h5);
        rd_chk("pre_rst_cnt", 32'h0C, 32'd5);
        RST_N = 1'b0;
        #1;
        intr_chk("rst_async_intr", 1'b0);
        rd_chk("rst_async_cnt",  32'h0C, 32'h0);
        rd_chk("rst_async_ctrl", 32'h00, 32'h0);
        rd_chk("rst_async_load", 32'h04, 32'h0);
        rd_chk("rst_async_stat", 32'h10, 32'h0);
        step();
        RST_N = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            intr_chk("post_rst_intr", 1'b0);
        end
        rd_chk("post_rst_stat", 32'h10, 32'h0);
        rd_chk("post_rst_ctrl", 32'h00, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
